// File: rtl/word_framer_pkg.sv
// rtl/word_framer_pkg.sv - shared definitions for the header-tagged word bus framer and checker
package word_framer_pkg;

  localparam int DEFAULT_BUS_SIZE  = 16;
  localparam int DEFAULT_WORD_SIZE = 4;
  localparam logic [3:0] DEFAULT_HEADER = 4'hF;

  // COLLECT gathers payload words; HOLD presents a finished frame until it is consumed
  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } frame_state_t;

  // Words per frame on the bus; the most significant word carries the header
  function automatic int word_num(input int bus_size, input int word_size);
    return bus_size / word_size;
  endfunction

endpackage

// File: rtl/word_framer.sv
// rtl/word_framer.sv - assembles payload words into header-tagged frames with a nonzero-word mask
module word_framer
  import word_framer_pkg::*;
#(
  parameter int BUS_SIZE  = DEFAULT_BUS_SIZE,
  parameter int WORD_SIZE = DEFAULT_WORD_SIZE,
  parameter int WORD_NUM  = word_num(BUS_SIZE, WORD_SIZE),
  parameter logic [WORD_SIZE-1:0] HEADER = WORD_SIZE'(DEFAULT_HEADER)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] word_in,
  input  logic                 word_valid,
  output logic                 word_ready,
  output logic [BUS_SIZE-1:0]  data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [WORD_NUM-1:0]  salida_control,
  output logic                 err,
  output logic                 next_err
);

  localparam int CNT_W = (WORD_NUM > 2) ? $clog2(WORD_NUM) : 1;
  localparam int PAY_W = BUS_SIZE - WORD_SIZE;

  frame_state_t state, state_next;
  logic [CNT_W-1:0] count;
  logic [PAY_W-1:0] payload, payload_next;
  logic [BUS_SIZE-1:0] frame_next;
  logic [WORD_NUM-1:0] frame_mask;
  logic accept, illegal, last_word, load_frame;

  // Ready is held low while reset is asserted so every output reads zero during reset
  assign word_ready = (state == COLLECT) && !reset;
  assign data_valid = (state == HOLD);
  assign accept     = word_valid & word_ready;
  assign illegal    = (word_in == HEADER);
  assign next_err   = accept & illegal;
  assign last_word  = (count == CNT_W'(WORD_NUM - 2));

  // Place the incoming word at its payload slot; slot 0 sits just below the header
  always_comb begin
    payload_next = payload;
    for (int i = 0; i < WORD_NUM - 1; i++) begin
      if (count == CNT_W'(i)) begin
        payload_next[(WORD_NUM-2-i)*WORD_SIZE +: WORD_SIZE] = word_in;
      end
    end
    frame_next = {HEADER, payload_next};
  end

  // Per-word nonzero detection over the frame about to be loaded
  genvar g;
  generate
    for (g = 0; g < WORD_NUM; g++) begin : g_word_nonzero_mask
      assign frame_mask[g] = |frame_next[g*WORD_SIZE +: WORD_SIZE];
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: a legal last word completes the frame; a downstream handshake releases it
  always_comb begin
    state_next = state;
    load_frame = 1'b0;
    case (state)
      COLLECT: begin
        if (accept && !illegal && last_word) begin
          state_next = HOLD;
          load_frame = 1'b1;
        end
      end
      HOLD: begin
        if (data_ready) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // Payload collection; an illegal word discards the partial frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      payload <= '0;
    end else if (accept) begin
      if (illegal) begin
        count   <= '0;
        payload <= '0;
      end else if (last_word) begin
        count   <= '0;
        payload <= payload_next;
      end else begin
        count   <= count + 1'b1;
        payload <= payload_next;
      end
    end
  end

  // Frame output and control mask persist until the next complete frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_out       <= '0;
      salida_control <= '0;
    end else if (load_frame) begin
      data_out       <= frame_next;
      salida_control <= frame_mask;
    end
  end

  // Error flag trails the illegal accept by one cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else begin
      err <= next_err;
    end
  end

endmodule

// File: doc/word_framer.md
Name: word_framer

Overview:
- Transmit-side framer for the header-tagged word bus (BUS_SIZE bus split into WORD_NUM words of WORD_SIZE bits; the most significant word is the header).
- Accepts a serial stream of payload words over a valid/ready handshake and assembles each frame: HEADER in the MSW, then WORD_NUM-1 payload words.
- Presents the frame on data_out with a per-word nonzero control mask, and flags illegal payload words (equal to HEADER).
- Produces exactly the frames the downstream frame checker consumes.

Parameters:
- BUS_SIZE, 16, width of the assembled bus
- WORD_SIZE, 4, width of one word; BUS_SIZE must be a multiple; WORD_NUM >= 2
- WORD_NUM, BUS_SIZE/WORD_SIZE, words per frame (derived; do not override)
- HEADER, 'hF (WORD_SIZE bits), header value written into the MSW; illegal as payload

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- word_in  in  WORD_SIZE  payload word
- word_valid  in  1  word_in is valid this cycle
- word_ready  out  1  framer accepts word_in this cycle
- data_out  out  BUS_SIZE  assembled frame {HEADER, w0, w1, ..., w(WORD_NUM-2)}
- data_valid  out  1  data_out holds a complete, unconsumed frame
- data_ready  in  1  downstream consumes data_out when data_valid is high
- salida_control  out  WORD_NUM  bit i = 1 iff word i of data_out is nonzero
- err  out  1  registered one-cycle pulse after an illegal payload word is accepted
- next_err  out  1  combinational: an illegal payload word is being accepted this cycle

Behaviour:
- Reset (asynchronous assert, synchronous release): state=COLLECT, count=0, payload cleared. data_out=0, salida_control=0, data_valid=0, err=0.
- Accept event: word_valid & word_ready.
- Two states: COLLECT and HOLD.
- COLLECT:
  - word_ready=1, data_valid=0.
  - Legal word accepted, count < WORD_NUM-2: store at payload position count (first word goes directly below the header); count+1.
  - Legal word accepted, count = WORD_NUM-2: next cycle, data_out = {HEADER, payload incl. this word}, salida_control updated from the same value, data_valid=1, state -> HOLD, count -> 0. Latency: data_valid rises the cycle after the last payload word is accepted.
  - Illegal word accepted (word_in == HEADER): next_err=1 this cycle; err=1 next cycle only; partial frame discarded; count -> 0; stay in COLLECT. data_out and salida_control are not changed.
  - No accept: hold all state.
- HOLD:
  - word_ready=0, so next_err=0. data_valid=1.
  - data_out and salida_control are stable.
  - data_ready=1: state -> COLLECT; data_valid=0 next cycle. The first word of the next frame is accepted no earlier than that cycle.
- next_err = word_valid & word_ready & (word_in == HEADER); no other term.
- After a handshake, data_out and salida_control retain the last frame; only data_valid drops.
- salida_control[WORD_NUM-1] is 1 whenever a frame is loaded (HEADER nonzero). Its reset value is 0.
- Illegal word on the count = WORD_NUM-2 position: handled as the illegal case; no frame is emitted.
- Reset mid-collection or in HOLD: partial or held frame lost; outputs return to reset values immediately.

Decomposition:
- Shared package: HEADER default, the WORD_NUM derivation, and the COLLECT/HOLD state encoding. The same package serves the frame checker.
- No sub-module. The per-word nonzero detection is a generate loop used identically by the checker; it may be factored as word_nonzero_mask if shared.

Test Plan:
- Reset held 3 cycles, then release; send words 1,2,0 back-to-back with data_ready=1 -> next_err=0 throughout; cycle after word 0: data_out='hF120, salida_control=4'b1110, data_valid=1 for one cycle; afterwards data_out holds 'hF120 with data_valid=0.
- Send 7,5,1 with data_ready=0 for 3 cycles -> data_out='hF751, control=4'b1111; data_valid and data_out stable; word_ready=0; word_valid ignored; handshake on data_ready=1 -> data_valid=0 next cycle.
- Send 1, F, then 2,0,3 -> next_err=1 in the F cycle; err=1 the next cycle only; no frame for {1,F}; then data_out='hF203, control=4'b1101.
- Send F,F consecutively -> two next_err pulses and two consecutive err pulses; data_out unchanged from the prior frame.
- Send A,0 then assert reset for 1 cycle; send 9,D,0 -> all outputs 0 during reset; first frame after release is 'hF9D0 with control=4'b1110 (A,0 discarded).
- Stream two frames (6,9,9 and 0,0,0) with data_ready=1 -> 'hF699 with control=4'b1111, then 'hF000 with control=4'b1000; word_ready low exactly one cycle between frames.
